lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_align.sv | 58 +++++
 rtl/lsu.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM encoding, funct3 access
// codes, error codes and the request legality check used when a start is accepted.
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3B  = 3'b000;
    localparam logic [2:0] F3H  = 3'b001;
    localparam logic [2:0] F3W  = 3'b010;
    localparam logic [2:0] F3Bu = 3'b100;
    localparam logic [2:0] F3Hu = 3'b101;

    localparam logic [2:0] ErrNone       = 3'd0;
    localparam logic [2:0] ErrLoadMisal  = 3'd1;
    localparam logic [2:0] ErrStoreMisal = 3'd2;
    localparam logic [2:0] ErrTimeout    = 3'd3;
    localparam logic [2:0] ErrIllegal    = 3'd4;

    // Classify a request before any bus activity; ErrNone means it may go to the bus.
    function automatic logic [2:0] req_check(input logic       is_store,
                                             input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
        logic [2:0] misal;
        misal = is_store ? ErrStoreMisal : ErrLoadMisal;
        case (funct3)
            F3B:     req_check = ErrNone;
            F3H:     req_check = addr_lo[0] ? misal : ErrNone;
            F3W:     req_check = (addr_lo != 2'b00) ? misal : ErrNone;
            F3Bu:    req_check = is_store ? ErrIllegal : ErrNone;
            F3Hu:    req_check = is_store ? ErrIllegal : (addr_lo[0] ? misal : ErrNone);
            default: req_check = ErrIllegal;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte strobes and lane replication, plus load
// byte/halfword selection with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lanes,
    output logic [31:0] load_data
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;

    assign byte_shift = rdata_raw >> {addr_lo, 3'b000};
    assign half_shift = rdata_raw >> {addr_lo[1], 4'b0000};

    // Store strobes and replicated write data; loads never strobe.
    always_comb begin
        wstrb       = 4'b0000;
        wdata_lanes = wdata;
        case (funct3)
            F3B: begin
                wstrb       = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
            end
            F3H: begin
                wstrb       = 4'b0011 << addr_lo;
                wdata_lanes = {2{wdata[15:0]}};
            end
            F3W:     wstrb = 4'b1111;
            default: wstrb = 4'b0000;
        endcase
        if (!is_store) begin
            wstrb = 4'b0000;
        end
    end

    // Load result extraction; stores return zero.
    always_comb begin
        load_data = 32'h0;
        if (!is_store) begin
            case (funct3)
                F3B:     load_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
                F3H:     load_data = {{16{half_shift[15]}}, half_shift[15:0]};
                F3W:     load_data = rdata_raw;
                F3Bu:    load_data = {24'h0, byte_shift[7:0]};
                F3Hu:    load_data = {16'h0, half_shift[15:0]};
                default: load_data = 32'h0;
            endcase
        end
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request from execute, performs a single bus
// handshake with a timeout, and reports the result with a one-cycle done pulse.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [2:0]  err_code,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT);

    lsu_state_e      state_q, state_d;
    logic            is_store_q, is_store_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [2:0]      code_q, code_d;

    logic [3:0]      wstrb_c;
    logic [31:0]     wdata_c;
    logic [31:0]     load_c;
    logic [2:0]      req_code;
    logic [CntW-1:0] cnt_inc;

    lsu_align u_align (
        .is_store    (is_store_q),
        .funct3      (funct3_q),
        .addr_lo     (addr_q[1:0]),
        .wdata       (wdata_q),
        .rdata_raw   (bus_rdata),
        .wstrb       (wstrb_c),
        .wdata_lanes (wdata_c),
        .load_data   (load_c)
    );

    assign req_code = req_check(is_store, funct3, addr[1:0]);
    assign cnt_inc  = cnt_q + 1'b1;

    // State and latched request; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            cnt_q      <= '0;
            rdata_q    <= 32'h0;
            code_q     <= ErrNone;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            code_q     <= code_d;
        end
    end

    // Next-state: accept in IDLE, handshake or time out in WAIT, single-cycle RESP.
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        code_d     = code_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    is_store_d = is_store;
                    funct3_d   = funct3;
                    addr_d     = addr;
                    wdata_d    = wdata;
                    rdata_d    = 32'h0;
                    cnt_d      = '0;
                    code_d     = req_code;
                    // Rejected requests skip the bus entirely.
                    state_d    = (req_code != ErrNone) ? StResp : StWait;
                end
            end
            StWait: begin
                if (bus_ready) begin
                    rdata_d = load_c;
                    code_d  = ErrNone;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntLimit) begin
                        rdata_d = 32'h0;
                        code_d  = ErrTimeout;
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                code_d  = ErrNone;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state so they follow the asynchronous reset immediately.
    always_comb begin
        busy      = (state_q != StIdle);
        done      = (state_q == StResp);
        err       = done && (code_q != ErrNone);
        err_code  = done ? code_q : ErrNone;
        rdata     = done ? rdata_q : 32'h0;
        bus_valid = (state_q == StWait);
        bus_we    = bus_valid && is_store_q;
        bus_addr  = bus_valid ? {addr_q[31:2], 2'b00} : 32'h0;
        bus_wstrb = bus_valid ? wstrb_c : 4'b0000;
        bus_wdata = bus_valid ? wdata_c : 32'h0;
    end

endmodule
